// File: rtl/shift_unit.sv
// Parametrised universal shift register with a count-controlled serial sequencer.
// Direct ops shift/rotate q by amt; a start launches an N-bit sdo/sdi exchange.
module shift_unit #(
  parameter int N  = 8,
  parameter int AW = $clog2(N),
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          msb_in,
  input  logic          lsb_in,
  input  logic          start,
  input  logic          dir,
  input  logic          sdi,
  output logic [N-1:0]  q,
  output logic          sdo,
  output logic          busy,
  output logic          done,
  output logic          dbg_state
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_LSL  = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sdir;

  logic [AW-1:0]  k;
  logic [2*N-1:0] right_src;
  logic [2*N-1:0] left_src;
  logic [2*N-1:0] right_res;
  logic [2*N-1:0] left_res;
  logic [N-1:0]   op_next;

  // Out-of-range amounts (only reachable when N is not a power of 2) act as k=0.
  assign k = (32'(amt) < 32'(N)) ? amt : '0;

  // Right ops shift a {fill, q} pair down and keep the low half; left ops
  // shift a {q, fill} pair up and keep the high half. Rotates use q as fill.
  always_comb begin
    right_src = {q, q};
    left_src  = {q, q};
    case (op)
      OP_SHR:  right_src = {{N{msb_in}}, q};
      OP_ASR:  right_src = {{N{q[N-1]}}, q};
      OP_SHL:  left_src  = {q, {N{lsb_in}}};
      OP_LSL:  left_src  = {q, {N{1'b0}}};
      default: begin
        right_src = {q, q};
        left_src  = {q, q};
      end
    endcase
    right_res = right_src >> k;
    left_res  = left_src << k;
  end

  always_comb begin
    op_next = q;
    case (op)
      OP_HOLD: op_next = q;
      OP_LOAD: op_next = d;
      OP_SHR, OP_ROR, OP_ASR: op_next = right_res[N-1:0];
      OP_SHL, OP_ROL, OP_LSL: op_next = left_res[2*N-1:N];
      default: op_next = q;
    endcase
  end

  assign sdo       = sdir ? q[0] : q[N-1];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      sdir  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q     <= d;
            cnt   <= CW'(N);
            sdir  <= dir;
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (en) begin
            q <= op_next;
          end
        end
        SHIFT: begin
          q   <= sdir ? {sdi, q[N-1:1]} : {q[N-2:0], sdi};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (N=8): direct ops, both sequence orders,
// interference while busy, mid-sequence reset and restart in the done cycle.
module tb_shift_unit;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  d;
  logic          msb_in;
  logic          lsb_in;
  logic          start;
  logic          dir;
  logic          sdi;
  logic [N-1:0]  q;
  logic          sdo;
  logic          busy;
  logic          done;
  logic          dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  shift_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .amt(amt), .d(d),
    .msb_in(msb_in), .lsb_in(lsb_in), .start(start), .dir(dir), .sdi(sdi),
    .q(q), .sdo(sdo), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled at the same point, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a, input logic [N-1:0] dv);
    en  = 1'b1;
    op  = o;
    amt = a;
    d   = dv;
    tick();
    en = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] dv);
    do_op(3'd1, '0, dv);
  endtask

  // Runs a full sequence; sdi_pat is fed in sampling order (index 0 first).
  // Optionally pulses start/en+LOAD at shift index 'poke' (-1 = none).
  task automatic run_seq(input string tag, input logic [N-1:0] dv, input logic dr,
                         input logic [N-1:0] sdi_pat, input int poke,
                         input logic [N-1:0] exp_q);
    logic [N-1:0] dcopy;
    dcopy = dv;
    start = 1'b1;
    d     = dv;
    dir   = dr;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check({tag, "_sdo"}, sdo, dr ? dcopy[i] : dcopy[N-1-i]);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_done_low"}, done, 1'b0);
      sdi = sdi_pat[i];
      if (i == poke) begin
        start = 1'b1;
        en    = 1'b1;
        op    = 3'd1;
        d     = '0;
        dir   = ~dr;
      end
      tick();
      start = 1'b0;
      en    = 1'b0;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_q"}, q, exp_q);
  endtask

  logic [N-1:0] pat;
  logic [N-1:0] pat_rev;
  int           done_seen;

  initial begin
    rst = 1'b0; en = 1'b0; op = '0; amt = '0; d = '0;
    msb_in = 1'b0; lsb_in = 1'b0; start = 1'b0; dir = 1'b0; sdi = 1'b0;
    #1;
    check("reset_q", q, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Async reset with nonzero q, mid-cycle
    load(8'h5A);
    check("load_5a", q, 8'h5A);
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_sdo", sdo, 1'b0);
    rst = 1'b1;
    tick();

    // Rotates
    load(8'hB4);
    do_op(3'd4, 3'd3, 8'h00);
    check("ror3", q, 8'h96);
    load(8'hB4);
    do_op(3'd5, 3'd3, 8'h00);
    check("rol3", q, 8'hA5);
    do_op(3'd4, 3'd0, 8'h00);
    check("ror0", q, 8'hA5);
    do_op(3'd5, 3'd0, 8'h00);
    check("rol0", q, 8'hA5);

    // Fills from 0x96
    load(8'h96);
    do_op(3'd6, 3'd2, 8'h00);
    check("asr2", q, 8'hE5);
    load(8'h96);
    msb_in = 1'b0;
    do_op(3'd2, 3'd2, 8'h00);
    check("shr2_fill0", q, 8'h25);
    load(8'h96);
    msb_in = 1'b1;
    do_op(3'd2, 3'd2, 8'h00);
    check("shr2_fill1", q, 8'hE5);
    msb_in = 1'b0;
    load(8'h96);
    lsb_in = 1'b1;
    do_op(3'd3, 3'd4, 8'h00);
    check("shl4_fill1", q, 8'h6F);
    lsb_in = 1'b0;
    load(8'h96);
    do_op(3'd7, 3'd1, 8'h00);
    check("lsl1", q, 8'h2C);
    load(8'h96);
    do_op(3'd7, 3'd7, 8'h00);
    check("lsl7", q, 8'h00);
    load(8'h81);
    do_op(3'd4, 3'd7, 8'h00);
    check("ror7", q, 8'h03);
    do_op(3'd0, 3'd5, 8'hFF);
    check("hold", q, 8'h03);
    en = 1'b0; op = 3'd1; d = 8'hFF;
    tick();
    check("en0_load", q, 8'h03);

    // MSB-first: sdi carries 0x3C MSB-first
    pat = 8'h3C;
    for (int i = 0; i < N; i++) pat_rev[i] = pat[N-1-i];
    run_seq("seq_msb", 8'hA5, 1'b0, pat_rev, -1, 8'h3C);
    tick();
    check("seq_msb_done_clear", done, 1'b0);

    // LSB-first, sdi held high
    run_seq("seq_lsb", 8'hA5, 1'b1, 8'hFF, -1, 8'hFF);
    tick();
    check("seq_lsb_done_clear", done, 1'b0);

    // Interference: start/en/LOAD pulsed mid-sequence must be ignored
    run_seq("seq_poke", 8'hC3, 1'b0, pat_rev, 3, 8'h3C);

    // Restart accepted in the done cycle
    start = 1'b1;
    d     = 8'h0F;
    dir   = 1'b0;
    tick();
    start = 1'b0;
    check("restart_busy", busy, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_q", q, 8'h0F);
    check("restart_sdo", sdo, 1'b0);

    // Reset after 4 shifts: no done pulse afterwards
    sdi = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_q", q, 8'hFF);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    tick();
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Parametrised successor to the 8-bit universal shift register functional unit.
- Adds a configurable width N and a multi-bit shift amount for every shift/rotate mode.
- Adds a count-controlled serial sequencer (start/busy/done) that shifts N bits out on sdo while capturing sdi. It serves as the datapath for the bus controller's byte transfers.

Parameters:
- N, 8, register width in bits (N >= 2).
- AW, $clog2(N), width of the shift-amount input.
- CW, $clog2(N+1), width of the internal sequence bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  perform op this cycle (ignored while busy).
- op  input  3  0 HOLD, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 ASR, 7 LSL.
- amt  input  AW  shift/rotate amount, 0..N-1.
- d  input  N  parallel load data.
- msb_in  input  1  fill bit for SHR.
- lsb_in  input  1  fill bit for SHL.
- start  input  1  begin N-bit serial sequence.
- dir  input  1  sequence order: 0 MSB-first, 1 LSB-first; sampled with start.
- sdi  input  1  serial data in during sequence.
- q  output  N  register contents.
- sdo  output  1  serial data out.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (rst=0, async): q=0, busy=0, done=0, counter=0, stored dir=0, FSM=IDLE. sdo therefore reads 0.
- All state updates on posedge clk. Every op takes effect at the sampling edge (latency 1).
- Direct ops (IDLE, en=1, start=0), with k = amt:
  - HOLD: q unchanged.
  - LOAD: q <= d.
  - SHR: q >> k; top k bits filled with msb_in.
  - SHL: q << k; low k bits filled with lsb_in.
  - ROR / ROL: rotate by k.
  - ASR: q >> k; top k bits filled with q[N-1].
  - LSL: q << k; zero fill.
- k=0 leaves q unchanged for every shift/rotate op. amt values >= N (possible when N is not a power of 2) are treated as k=0.
- IDLE with en=0 and start=0: q holds.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge T:
  - q <= d; counter <= N; stored dir <= dir; busy <= 1; go to SHIFT.
  - start has priority over en/op in the same cycle.
- SHIFT, each edge:
  - dir=0: q <= {q[N-2:0], sdi}. dir=1: q <= {sdi, q[N-1:1]}.
  - counter decrements.
  - On the edge where counter goes 1->0: busy <= 0, done <= 1, go to IDLE.
- Sequence timing for a start at edge T: shifts occur at edges T+1..T+N. busy is high for cycles T..T+N-1 (N cycles after T). done is high for exactly the one cycle after edge T+N.
- sdo is combinational from q: q[N-1] if stored dir=0, else q[0]. Bit i of the sequence is valid during the cycle after edge T+i.
- After the sequence, q holds the N sdi bits sampled at edges T+1..T+N, first-sampled bit deepest.
- While busy: start, en, op, amt, d are ignored; the stored dir is used.
- During the done cycle the block is IDLE and accepts a new start or op. done clears at the next edge regardless.
- Reset mid-sequence: immediate return to reset values; no done pulse.
- done is 0 in every cycle except the single end-of-sequence cycle.

Test Plan:
- Reset: assert rst=0 with nonzero q mid-cycle -> q=0x00, busy=0, done=0, sdo=0 immediately, before any clock edge.
- N=8 rotates: LOAD d=0xB4, then ROR amt=3 -> q=0x96. Reload 0xB4, then ROL amt=3 -> q=0xA5. ROR amt=0 -> q unchanged.
- Fills: from q=0x96:
  - ASR amt=2 -> 0xE5.
  - SHR amt=2, msb_in=0 -> 0x25.
  - SHL amt=4, lsb_in=1 -> 0x6F.
  - LSL amt=1 -> 0x2C.
  - en=0 with op=LOAD -> q holds.
- Sequence MSB-first: start, d=0xA5, dir=0; drive sdi with the bits of 0x3C MSB-first, one per shift edge -> sdo shows 1,0,1,0,0,1,0,1; busy high for 8 cycles; done high for one cycle; final q=0x3C.
- Sequence LSB-first: start, d=0xA5, dir=1, sdi=1 constant -> sdo shows 1,0,1,0,0,1,0,1 (LSB first); final q=0xFF; done once.
- Interference and reset: during a sequence, pulse start and en (op=LOAD, d=0x00) -> ignored, bit stream unaffected. Separately, assert rst=0 after 4 shifts -> q=0, busy=0, no done pulse. A new start in the done cycle is accepted and busy rises at that edge.
